// File: rtl/gpu_lbus_ctrl.sv
// Local-bus access sequencer behind gpu_cpu. It decodes each CPU request to the local RAM,
// the register file or unmapped space, and returns ack and mem_data after that target's wait states.
module gpu_lbus_ctrl #(
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned REG_WAIT   = 2,
    parameter int unsigned UNMAP_WAIT = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        ioreq,
    input  logic [12:0] cpuaddr,
    input  logic [31:0] cpudata,
    input  logic        cpuwr,
    output logic        ack,
    output logic [31:0] mem_data,
    output logic [9:0]  ram_addr,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [3:0]  reg_sel,
    output logic        reg_stb,
    output logic        reg_we,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    output logic        bus_err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_ACC,
        S_REG_WAITST,
        S_REG_ACC,
        S_UNMAP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {D_RAM, D_REG, D_UNMAP} dec_t;

    localparam logic [3:0] C_RAM_LAT    = 4'(RAM_LAT);
    localparam logic [3:0] C_REG_WAIT   = 4'(REG_WAIT);
    localparam logic [3:0] C_UNMAP_WAIT = 4'(UNMAP_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_dec;
    logic        r_cs_done;
    logic        r_wr;
    logic [9:0]  r_ram_addr;
    logic [3:0]  r_reg_sel;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_data;
    logic        r_bus_err;
    dec_t        w_dec;
    logic        w_accept;
    logic        w_ram_cs;
    logic        w_ram_capture;
    logic        w_reg_stb;
    logic        w_unmap_end;

    always_comb begin
        unique case (cpuaddr[12:10])
            3'b000:  w_dec = D_RAM;
            3'b100:  w_dec = D_REG;
            default: w_dec = D_UNMAP;
        endcase
    end

    // Saturating decrement: wait counters stop at zero instead of wrapping.
    assign w_cnt_dec = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        w_ram_cs      = 1'b0;
        w_ram_capture = 1'b0;
        w_reg_stb     = 1'b0;
        w_unmap_end   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ioreq) begin
                    w_accept = 1'b1;
                    unique case (w_dec)
                        D_RAM: begin
                            w_state_nxt = S_RAM_ACC;
                            w_cnt_nxt   = cpuwr ? 4'd1 : C_RAM_LAT;
                        end
                        D_REG: begin
                            w_state_nxt = (C_REG_WAIT == 4'd0) ? S_REG_ACC : S_REG_WAITST;
                            w_cnt_nxt   = C_REG_WAIT;
                        end
                        default: begin
                            w_state_nxt = S_UNMAP;
                            w_cnt_nxt   = C_UNMAP_WAIT;
                        end
                    endcase
                end
            end
            S_RAM_ACC: begin
                if (!r_cs_done) begin
                    w_ram_cs = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                    if (r_cnt <= 4'd1) begin
                        w_ram_capture = !r_wr;
                        w_state_nxt   = S_DONE;
                    end
                end
            end
            S_REG_WAITST: begin
                w_cnt_nxt = w_cnt_dec;
                if (r_cnt <= 4'd1) w_state_nxt = S_REG_ACC;
            end
            S_REG_ACC: begin
                w_reg_stb   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_UNMAP: begin
                w_cnt_nxt = w_cnt_dec;
                if (r_cnt <= 4'd1) begin
                    w_unmap_end = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_cs_done  <= 1'b0;
            r_wr       <= 1'b0;
            r_ram_addr <= 10'd0;
            r_reg_sel  <= 4'd0;
            r_wdata    <= 32'd0;
            r_mem_data <= 32'd0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cs_done <= (w_state_nxt == S_RAM_ACC) && (w_ram_cs || r_cs_done);
            if (w_accept) begin
                r_wr    <= cpuwr;
                r_wdata <= cpudata;
                if (w_dec == D_RAM) r_ram_addr <= cpuaddr[9:0];
                if (w_dec == D_REG) r_reg_sel  <= cpuaddr[3:0];
            end
            if (w_ram_capture)                r_mem_data <= ram_rdata;
            else if (w_reg_stb && !r_wr)      r_mem_data <= reg_rdata;
            else if (w_unmap_end && !r_wr)    r_mem_data <= 32'd0;
            // A new error outranks a clear arriving in the same cycle.
            if (w_unmap_end)  r_bus_err <= 1'b1;
            else if (err_clr) r_bus_err <= 1'b0;
        end
    end

    assign ack       = (r_state == S_DONE);
    assign mem_data  = r_mem_data;
    assign ram_addr  = r_ram_addr;
    assign ram_cs    = w_ram_cs;
    assign ram_we    = w_ram_cs & r_wr;
    assign ram_wdata = r_wdata;
    assign reg_sel   = r_reg_sel;
    assign reg_stb   = w_reg_stb;
    assign reg_we    = w_reg_stb & r_wr;
    assign reg_wdata = r_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_gpu_lbus_ctrl.sv
// Directed bench for gpu_lbus_ctrl with default parameters (RAM_LAT=1, REG_WAIT=2, UNMAP_WAIT=4).
// Inputs change and outputs are sampled on the falling edge; cycle N is N rising edges after ioreq is raised.
module tb_gpu_lbus_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        ioreq;
    logic [12:0] cpuaddr;
    logic [31:0] cpudata;
    logic        cpuwr;
    logic        ack;
    logic [31:0] mem_data;
    logic [9:0]  ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [3:0]  reg_sel;
    logic        reg_stb;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        bus_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [0:1023];

    gpu_lbus_ctrl dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .ioreq     (ioreq),
        .cpuaddr   (cpuaddr),
        .cpudata   (cpudata),
        .cpuwr     (cpuwr),
        .ack       (ack),
        .mem_data  (mem_data),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .reg_sel   (reg_sel),
        .reg_stb   (reg_stb),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .bus_err   (bus_err),
        .err_clr   (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // One-cycle-latency RAM; read data is valid for exactly one cycle after the strobe.
    always @(posedge sys_clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_cs) ram_rdata <= ram_mem[ram_addr];
        else        ram_rdata <= 32'hBAD0_BAD0;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        ioreq     = 1'b0;
        cpuaddr   = 13'd0;
        cpudata   = 32'd0;
        cpuwr     = 1'b0;
        err_clr   = 1'b0;
        reg_rdata = 32'd0;
        cyc(3);

        // Reset state
        check1 ("rst_ack",      ack,      1'b0);
        check1 ("rst_ram_cs",   ram_cs,   1'b0);
        check1 ("rst_reg_stb",  reg_stb,  1'b0);
        check1 ("rst_bus_err",  bus_err,  1'b0);
        check32("rst_mem_data", mem_data, 32'd0);
        check32("rst_ram_addr", 32'(ram_addr), 32'd0);
        check32("rst_reg_sel",  32'(reg_sel),  32'd0);
        check32("rst_wdata",    ram_wdata, 32'd0);
        reset = 1'b0;
        cyc(1);

        // RAM write 0x005 <= DEADBEEF; inputs scrambled after the latch cycle
        ioreq = 1'b1; cpuaddr = 13'h005; cpudata = 32'hDEAD_BEEF; cpuwr = 1'b1;
        cyc(1);
        check1 ("wr_c1_ram_cs",  ram_cs, 1'b1);
        check1 ("wr_c1_ram_we",  ram_we, 1'b1);
        check32("wr_c1_addr",    32'(ram_addr), 32'h005);
        check32("wr_c1_wdata",   ram_wdata, 32'hDEAD_BEEF);
        check1 ("wr_c1_ack",     ack, 1'b0);
        cpuaddr = 13'h1ABC; cpudata = 32'h0; cpuwr = 1'b0;
        cyc(1);
        check1 ("wr_c2_ram_cs",  ram_cs, 1'b0);
        check1 ("wr_c2_ack",     ack, 1'b0);
        cyc(1);
        check1 ("wr_c3_ack",     ack, 1'b1);
        ioreq = 1'b0;
        cyc(1);
        check1 ("wr_c4_ack",     ack, 1'b0);

        // RAM read 0x005
        ioreq = 1'b1; cpuaddr = 13'h005; cpuwr = 1'b0;
        cyc(1);
        check1 ("rd_c1_ram_cs",  ram_cs, 1'b1);
        check1 ("rd_c1_ram_we",  ram_we, 1'b0);
        check32("rd_c1_addr",    32'(ram_addr), 32'h005);
        cyc(1);
        check1 ("rd_c2_ack",     ack, 1'b0);
        cyc(1);
        check1 ("rd_c3_ack",     ack, 1'b1);
        check32("rd_c3_data",    mem_data, 32'hDEAD_BEEF);
        ioreq = 1'b0;
        cyc(1);

        // RAM write 0x006 <= 11111111 leaves mem_data alone
        ioreq = 1'b1; cpuaddr = 13'h006; cpudata = 32'h1111_1111; cpuwr = 1'b1;
        cyc(3);
        check1 ("wr6_ack",       ack, 1'b1);
        check32("wr6_mem_hold",  mem_data, 32'hDEAD_BEEF);
        ioreq = 1'b0;
        cyc(1);

        // Register read 0x1003, two wait states
        reg_rdata = 32'h1234_5678;
        ioreq = 1'b1; cpuaddr = 13'h1003; cpuwr = 1'b0;
        cyc(1);
        check1 ("reg_c1_stb",    reg_stb, 1'b0);
        cyc(1);
        check1 ("reg_c2_stb",    reg_stb, 1'b0);
        check1 ("reg_c2_ack",    ack, 1'b0);
        cyc(1);
        check1 ("reg_c3_stb",    reg_stb, 1'b1);
        check32("reg_c3_sel",    32'(reg_sel), 32'd3);
        check1 ("reg_c3_we",     reg_we, 1'b0);
        check1 ("reg_c3_ack",    ack, 1'b0);
        cyc(1);
        check1 ("reg_c4_ack",    ack, 1'b1);
        check32("reg_c4_data",   mem_data, 32'h1234_5678);
        ioreq = 1'b0; reg_rdata = 32'd0;
        cyc(1);

        // Unmapped read 0x0800
        ioreq = 1'b1; cpuaddr = 13'h0800; cpuwr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            check1 ("unm_wait_ack", ack, 1'b0);
        end
        check1 ("unm_c4_bus_err", bus_err, 1'b0);
        cyc(1);
        check1 ("unm_c5_ack",     ack, 1'b1);
        check32("unm_c5_data",    mem_data, 32'd0);
        check1 ("unm_c5_bus_err", bus_err, 1'b1);
        ioreq = 1'b0;
        cyc(1);
        err_clr = 1'b1;
        cyc(1);
        check1 ("errclr_bus_err", bus_err, 1'b0);
        err_clr = 1'b0;

        // Unmapped write 0x1C00 with err_clr coinciding with the set
        ioreq = 1'b1; cpuaddr = 13'h1C00; cpuwr = 1'b1;
        cyc(4);
        err_clr = 1'b1;
        cyc(1);
        check1 ("setclr_ack",     ack, 1'b1);
        check1 ("setclr_bus_err", bus_err, 1'b1);
        err_clr = 1'b0; ioreq = 1'b0;
        cyc(1);
        check1 ("setclr_sticky",  bus_err, 1'b1);

        // Back-to-back RAM reads with ioreq held high throughout
        ioreq = 1'b1; cpuaddr = 13'h006; cpuwr = 1'b0;
        cyc(3);
        check1 ("b2b_a_ack",     ack, 1'b1);
        check32("b2b_a_data",    mem_data, 32'h1111_1111);
        cpuaddr = 13'h005;
        cyc(1);
        check1 ("b2b_idle_ack",  ack, 1'b0);
        check1 ("b2b_idle_cs",   ram_cs, 1'b0);
        cyc(1);
        check1 ("b2b_b_cs",      ram_cs, 1'b1);
        check32("b2b_b_addr",    32'(ram_addr), 32'h005);
        check1 ("b2b_b_c1_ack",  ack, 1'b0);
        cyc(1);
        check1 ("b2b_b_c2_ack",  ack, 1'b0);
        cyc(1);
        check1 ("b2b_b_ack",     ack, 1'b1);
        check32("b2b_b_data",    mem_data, 32'hDEAD_BEEF);
        ioreq = 1'b0;
        cyc(1);
        check1 ("b2b_after_ack", ack, 1'b0);

        // ioreq dropped before ack: access still completes, exactly once
        ioreq = 1'b1; cpuaddr = 13'h006; cpuwr = 1'b0;
        cyc(1);
        check1 ("drop_c1_cs",    ram_cs, 1'b1);
        ioreq = 1'b0;
        cyc(2);
        check1 ("drop_c3_ack",   ack, 1'b1);
        check32("drop_c3_data",  mem_data, 32'h1111_1111);
        cyc(1);
        check1 ("drop_c4_ack",   ack, 1'b0);
        cyc(1);
        check1 ("drop_c5_ack",   ack, 1'b0);
        check1 ("drop_c5_cs",    ram_cs, 1'b0);

        // Reset while in REG_WAITST abandons the access
        reg_rdata = 32'h55AA_55AA;
        ioreq = 1'b1; cpuaddr = 13'h1002; cpuwr = 1'b0;
        cyc(1);
        reset = 1'b1; ioreq = 1'b0;
        cyc(1);
        check1 ("rstmid_stb",     reg_stb, 1'b0);
        check1 ("rstmid_ack",     ack, 1'b0);
        check1 ("rstmid_bus_err", bus_err, 1'b0);
        check32("rstmid_mem",     mem_data, 32'd0);
        check32("rstmid_sel",     32'(reg_sel), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check1 ("rstpost_stb", reg_stb, 1'b0);
            check1 ("rstpost_ack", ack, 1'b0);
        end

        // Fresh register write 0x13F5 (bits 9:4 ignored) after reset
        ioreq = 1'b1; cpuaddr = 13'h13F5; cpudata = 32'hCAFE_F00D; cpuwr = 1'b1;
        cyc(2);
        check1 ("rw_c2_stb",     reg_stb, 1'b0);
        cyc(1);
        check1 ("rw_c3_stb",     reg_stb, 1'b1);
        check1 ("rw_c3_we",      reg_we, 1'b1);
        check32("rw_c3_sel",     32'(reg_sel), 32'd5);
        check32("rw_c3_wdata",   reg_wdata, 32'hCAFE_F00D);
        cyc(1);
        check1 ("rw_c4_ack",     ack, 1'b1);
        check32("rw_c4_mem",     mem_data, 32'd0);
        ioreq = 1'b0;
        cyc(1);
        check1 ("rw_c5_ack",     ack, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
